// File: rtl/full_adder.sv
// One-bit full adder cell shared by the bit-serial multiplier datapath.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_mult_ctrl.sv
// Bit-serial unsigned multiplier controller built around one full_adder cell.
// Each ADD cycle folds one partial-product bit b[i]&a[j] into acc[i+j] with a
// rippling carry register. Rows run over columns 0..WIDTH; the extra column
// lands the row carry in acc[i+WIDTH].
// Optional feature: define SKIP_ZERO_EN to spend a single cycle on rows whose
// multiplier bit is 0.
module serial_mult_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned RW = (WIDTH > 1) ? $clog2(WIDTH) : 1;  // row index width
  localparam int unsigned JW = $clog2(WIDTH + 1);                // column index width
  localparam int unsigned AW = $clog2(2 * WIDTH);                // acc bit index width

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc;
  logic               carry;
  logic [RW-1:0]      i;
  logic [JW-1:0]      j;

  logic [WIDTH:0]     a_ext;
  logic [AW-1:0]      idx;
  logic               fa_a;
  logic               fa_b;
  logic               fa_s;
  logic               fa_cout;
  logic               last_row;
  logic               last_col;

  // Datapath operands for the current step; a[WIDTH] reads as 0.
  always_comb begin
    a_ext    = {1'b0, a_q};
    idx      = AW'(i) + AW'(j);
    fa_a     = acc[idx];
    fa_b     = b_q[i] & a_ext[j];
    last_row = (i == RW'(WIDTH - 1));
    last_col = (j == JW'(WIDTH));
  end

  full_adder u_fa (
    .A    (fa_a),
    .B    (fa_b),
    .Cin  (carry),
    .S    (fa_s),
    .Cout (fa_cout)
  );

  // Control FSM with registered outputs and the serial accumulator.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      i       <= '0;
      j       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            acc     <= '0;
            carry   <= 1'b0;
            i       <= '0;
            j       <= '0;
            product <= '0;
            busy    <= 1'b1;
            state   <= StAdd;
          end
        end

        StAdd: begin
`ifdef SKIP_ZERO_EN
          if (j == '0 && !b_q[i]) begin
            // Zero multiplier bit: the row adds nothing, move on in one cycle.
            if (last_row) begin
              busy  <= 1'b0;
              state <= StDone;
            end else begin
              i <= i + 1'b1;
            end
          end else
`endif
          begin
            acc[idx] <= fa_s;
            if (last_col) begin
              // Row carry-out is always 0 here, so it is dropped.
              j     <= '0;
              carry <= 1'b0;
              if (last_row) begin
                busy  <= 1'b0;
                state <= StDone;
              end else begin
                i <= i + 1'b1;
              end
            end else begin
              j     <= j + 1'b1;
              carry <= fa_cout;
            end
          end
        end

        StDone: begin
          done    <= 1'b1;
          product <= acc;
          state   <= StIdle;
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule
